// File: rtl/maj_net_pkg.sv
// Shared types and constants for the majority-inverter-graph evaluator.
// Contents:
//   NUM_IN, NUM_NODES    primary inputs and netlist storage depth
//   SIG_W                width of a signal index (constant 0, inputs, nodes)
//   ADDR_W, CFG_W, K_W   configuration address, data and node-counter widths
//   state_t              evaluator FSM states
//   node_cfg_t           one majority node: {inv[2:0], sel2, sel1, sel0}
//   out_cfg_t            output select: {inv, sel}
//   idx_node(k)          signal index of node k's result
package maj_net_pkg;

  localparam int NUM_IN    = 7;
  localparam int NUM_NODES = 8;
  localparam int SIG_W     = $clog2(1 + NUM_IN + NUM_NODES);
  localparam int ADDR_W    = $clog2(NUM_NODES + 1);
  localparam int CFG_W     = 3 * SIG_W + 3;
  localparam int K_W       = $clog2(NUM_NODES);

  localparam logic [SIG_W-1:0] IDX_CONST0 = '0;
  localparam logic [SIG_W-1:0] IDX_X_BASE = SIG_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    DONE
  } state_t;

  // Packed so that the layout matches cfg_data directly: inv on top, then
  // sel[2], sel[1], sel[0] down to bit 0.
  typedef struct packed {
    logic [2:0]            inv;
    logic [2:0][SIG_W-1:0] sel;
  } node_cfg_t;

  typedef struct packed {
    logic             inv;
    logic [SIG_W-1:0] sel;
  } out_cfg_t;

  function automatic logic [SIG_W-1:0] idx_node(input int k);
    return SIG_W'(NUM_IN + 1 + k);
  endfunction

endpackage

// File: rtl/maj3_node.sv
// Three-input majority with per-input inversion. Purely combinational; the
// evaluator time-shares a single instance across all netlist nodes.
// Ports:
//   a, b, c   selected signal values
//   inv       per-input inversion (inv[0] applies to a, inv[2] to c)
//   y         MAJ(a^inv0, b^inv1, c^inv2)
module maj3_node (
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic [2:0] inv,
  output logic       y
);

  logic pa, pb, pc;

  assign pa = a ^ inv[0];
  assign pb = b ^ inv[1];
  assign pc = c ^ inv[2];
  assign y  = (pa & pb) | (pa & pc) | (pb & pc);

endmodule

// File: rtl/maj_net_eval.sv
// Programmable MIG evaluator: holds a runtime-loaded netlist of NUM_NODES
// majority nodes, evaluates it one node per cycle on each accepted input
// vector and returns one classification bit over valid/ready.
// Optional feature macro: MAJ_EARLY_EXIT_EN -- adds a 'last node' field to the
// output register so evaluation can stop before NUM_NODES-1.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cfg_we/addr/data    config write; addr NUM_NODES selects the output register
//   cfg_err             one-cycle pulse when a write is dropped
//   in_valid/in_ready/x input vector handshake (ready only in IDLE)
//   out_valid/out_ready/out  result handshake; out held while out_valid
module maj_net_eval
  import maj_net_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [CFG_W-1:0]  cfg_data,
  output logic              cfg_err,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out
);

  state_t                state;
  logic [K_W-1:0]        k_q;
  logic [K_W-1:0]        last_k;
  logic [NUM_IN-1:0]     x_q;
  logic [NUM_NODES-1:0]  node_val;
  node_cfg_t             node_cfg [NUM_NODES];
  out_cfg_t              out_cfg;
  node_cfg_t             cur;
  logic [(1<<SIG_W)-1:0] sig_vec;
  logic                  maj_y;
  logic                  cfg_ok;

  // Flat signal space: index 0 is constant 0, then inputs, then node results.
  // Forward and self references land on node registers that were cleared at
  // capture, so they read as 0.
  always_comb begin
    // NOTE: assign a default before any partial update so no bit can hold its
    // old value, which would infer a latch.
    sig_vec                           = '0;
    sig_vec[IDX_X_BASE +: NUM_IN]     = x_q;
    sig_vec[idx_node(0) +: NUM_NODES] = node_val;
  end

  assign cur = node_cfg[k_q];

  maj3_node u_maj (
    .a   (sig_vec[cur.sel[0]]),
    .b   (sig_vec[cur.sel[1]]),
    .c   (sig_vec[cur.sel[2]]),
    .inv (cur.inv),
    .y   (maj_y)
  );

  assign in_ready = (state == IDLE);

`ifdef MAJ_EARLY_EXIT_EN
  logic [K_W-1:0] last_q;
  assign last_k = last_q;
`else
  assign last_k = K_W'(NUM_NODES - 1);
`endif

  // Evaluator FSM. DONE spends its first cycle registering the selected
  // signal, then holds out/out_valid until downstream accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k_q       <= '0;
      x_q       <= '0;
      node_val  <= '0;
      out_valid <= 1'b0;
      out       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples the
      // values from before the edge, independent of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q      <= x;
            node_val <= '0;
            k_q      <= '0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          node_val[k_q] <= maj_y;
          if (k_q == last_k) state <= DONE;
          else               k_q   <= k_q + K_W'(1);
        end
        DONE: begin
          if (!out_valid) begin
            out       <= sig_vec[out_cfg.sel] ^ out_cfg.inv;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Writes only land while idle, so an in-flight vector always sees a
  // consistent netlist. A write alongside in_valid lands at the capture edge
  // and is therefore used by that vector.
  assign cfg_ok = cfg_we && (state == IDLE) && (cfg_addr <= ADDR_W'(NUM_NODES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the netlist storage is reset deliberately: a cleared netlist
      // evaluates to a defined 0 rather than leftover contents.
      node_cfg <= '{default: '0};
      out_cfg  <= '0;
`ifdef MAJ_EARLY_EXIT_EN
      last_q   <= K_W'(NUM_NODES - 1);
`endif
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !cfg_ok;
      if (cfg_ok) begin
        if (cfg_addr < ADDR_W'(NUM_NODES)) begin
          node_cfg[cfg_addr[K_W-1:0]] <= node_cfg_t'(cfg_data);
        end else begin
          out_cfg <= out_cfg_t'(cfg_data[SIG_W:0]);
`ifdef MAJ_EARLY_EXIT_EN
          last_q  <= cfg_data[SIG_W+1 +: K_W];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_maj_net_eval.sv
// Directed testbench for maj_net_eval with an expected-result queue.
module tb_maj_net_eval;
  import maj_net_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [CFG_W-1:0]  cfg_data;
  logic              cfg_err;
  logic              in_valid;
  logic              in_ready;
  logic [NUM_IN-1:0] x;
  logic              out_valid;
  logic              out_ready;
  logic              out;

  maj_net_eval dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .cfg_err   (cfg_err),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
  );

  always #5 clk = ~clk;

  // Last-node field set to NUM_NODES-1 so output-register writes keep full
  // evaluation when the early-exit field is present.
  localparam logic [CFG_W-1:0] LAST_ALL = CFG_W'((NUM_NODES - 1) << (SIG_W + 1));
  localparam logic [ADDR_W-1:0] OUT_ADDR = ADDR_W'(NUM_NODES);

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int err_seen = 0;
  int accept_cyc;

  node_cfg_t      m_node [NUM_NODES];
  out_cfg_t       m_out;
  logic [K_W-1:0] m_last;
  logic           exp_q [$];

  always @(posedge clk) cyc++;
  always @(negedge clk) if (cfg_err === 1'b1) err_seen++;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference evaluation of the model netlist; unevaluated and forward nodes read 0.
  function automatic logic model(input logic [NUM_IN-1:0] xv);
    logic [(1<<SIG_W)-1:0] s;
    logic a, b, c;
    s = '0;
    s[NUM_IN:1] = xv;
    for (int k = 0; k < NUM_NODES; k++) begin
      if (k <= int'(m_last)) begin
        a = s[m_node[K_W'(k)].sel[0]] ^ m_node[K_W'(k)].inv[0];
        b = s[m_node[K_W'(k)].sel[1]] ^ m_node[K_W'(k)].inv[1];
        c = s[m_node[K_W'(k)].sel[2]] ^ m_node[K_W'(k)].inv[2];
        s[SIG_W'(NUM_IN + 1 + k)] = (a & b) | (a & c) | (b & c);
      end
    end
    return s[m_out.sel] ^ m_out.inv;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NUM_NODES; k++) m_node[K_W'(k)] = '0;
    m_out  = '0;
    m_last = K_W'(NUM_NODES - 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [ADDR_W-1:0] a, input logic [CFG_W-1:0] d,
                           input logic exp_err, input string tag);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
    check({tag, "_err"}, 32'(cfg_err), 32'(exp_err));
    if (exp_err) begin
      tick();
      check({tag, "_errpulse"}, 32'(cfg_err), 32'(0));
    end else if (int'(a) < NUM_NODES) begin
      m_node[a[K_W-1:0]] = node_cfg_t'(d);
    end else begin
      m_out = out_cfg_t'(d[SIG_W:0]);
`ifdef MAJ_EARLY_EXIT_EN
      m_last = d[SIG_W+1 +: K_W];
`endif
    end
  endtask

  task automatic start_vec(input logic [NUM_IN-1:0] xv, input logic e, input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    check({tag, "_ready"}, 32'(in_ready), 32'(1));
    exp_q.push_back(e);
    x = xv; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    accept_cyc = cyc;
    check({tag, "_busy"}, 32'(in_ready), 32'(0));
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    logic e;
    while (out_valid !== 1'b1 && n < 100) begin tick(); n++; end
    check({tag, "_lat"}, 32'(cyc - accept_cyc), 32'(int'(m_last) + 2));
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
    check({tag, "_out"}, 32'(out), 32'(e));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_idle"}, 32'(in_ready), 32'(1));
    check({tag, "_ovl"}, 32'(out_valid), 32'(0));
  endtask

  task automatic run(input logic [NUM_IN-1:0] xv, input logic e, input string tag);
    start_vec(xv, e, tag);
    wait_result(tag);
    release_out(tag);
  endtask

  initial begin
    logic [NUM_IN-1:0] xv;
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    in_valid = 1'b0; x = '0; out_ready = 1'b0;
    model_reset();
    tick(); tick();
    rst = 1'b0;

    // 1: reset defaults
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out", 32'(out), 32'(0));
    check("rst_cfg_err", 32'(cfg_err), 32'(0));
    run(7'h55, 1'b0, "t1_a");
    run(7'h7f, 1'b0, "t1_b");
    check("t1_no_err_pulse", 32'(err_seen), 32'(0));

    // Out-of-range config addresses are dropped with an error pulse.
    cfg_write(4'd9,  '1, 1'b1, "bad9");
    cfg_write(4'd15, '1, 1'b1, "bad15");

    // 2: node0 = MAJ(x0,x1,x4), out = node0
    cfg_write(4'd0, 15'h0521, 1'b0, "t2_n0");
    cfg_write(OUT_ADDR, 15'h0008 | LAST_ALL, 1'b0, "t2_o");
    run(7'b0010011, 1'b1, "t2_a");
    run(7'b0000001, 1'b0, "t2_b");
    run(7'b0010010, 1'b1, "t2_c");

    // 3: node1 = MAJ(x2,node0,x3), out = ~node1
    cfg_write(4'd1, 15'h0483, 1'b0, "t3_n1");
    cfg_write(OUT_ADDR, 15'h0019 | LAST_ALL, 1'b0, "t3_o");
    run(7'b0000111, 1'b0, "t3_a");
    run(7'b0000000, 1'b1, "t3_b");
    for (int i = 0; i < 6; i++) begin
      xv = NUM_IN'($urandom);
      run(xv, model(xv), "t3_rnd");
    end

    // 4: writes during EVAL and DONE are dropped and leave the result alone
    start_vec(7'b0000111, 1'b0, "t4");
    cfg_write(4'd0, 15'h0000, 1'b1, "t4_evalwr");
    wait_result("t4");
    cfg_write(OUT_ADDR, 15'h0000, 1'b1, "t4_donewr");
    check("t4_hold", 32'(out), 32'(0));
    release_out("t4");
    run(7'b0000111, 1'b0, "t4_old");

    // 5: backpressure in DONE
    start_vec(7'b0000000, 1'b1, "t5");
    wait_result("t5");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_out", 32'(out), 32'(1));
      check("t5_ovl", 32'(out_valid), 32'(1));
      check("t5_rdy", 32'(in_ready), 32'(0));
    end
    release_out("t5");

    // 6: reset mid-EVAL (out currently holds 1)
    start_vec(7'h7f, model(7'h7f), "t6");
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("t6_in_ready", 32'(in_ready), 32'(1));
    check("t6_out_valid", 32'(out_valid), 32'(0));
    check("t6_out", 32'(out), 32'(0));
    check("t6_cfg_err", 32'(cfg_err), 32'(0));
    exp_q.delete();
    model_reset();
    tick();
    rst = 1'b0;
    // Nodes must be cleared: out = node1 reads 0 even for all-ones input.
    cfg_write(OUT_ADDR, 15'h0009 | LAST_ALL, 1'b0, "t6_o");
    run(7'h7f, 1'b0, "t6_a");
    run(7'h00, 1'b0, "t6_b");

`ifdef MAJ_EARLY_EXIT_EN
    // Early exit after node1: latency last+2 = 3.
    cfg_write(4'd0, 15'h0521, 1'b0, "t7_n0");
    cfg_write(4'd1, 15'h0483, 1'b0, "t7_n1");
    cfg_write(OUT_ADDR, 15'h0029, 1'b0, "t7_o");
    check("t7_last", 32'(m_last), 32'(1));
    run(7'b0000111, 1'b1, "t7_a");
    run(7'b0000000, 1'b0, "t7_b");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
